// File: rtl/bin_oct_decoder_strobe.sv
// rtl/bin_oct_decoder_strobe.sv - 3-to-8 one-hot strobe decoder with hold timer, idle gap and done pulse
module bin_oct_decoder_strobe #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    out_nxt;
    logic          done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 8'h00;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
            done  <= done_nxt;
        end
    end

    // The code is only needed while HOLD runs, and out already carries it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = HOLD;
                    out_nxt   = 8'h01 << in_code;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    out_nxt  = 8'h00;
                    done_nxt = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                out_nxt   = 8'h00;
            end
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_bin_oct_decoder_strobe.sv
// tb/tb_bin_oct_decoder_strobe.sv - scoreboard bench for two decoder configurations (4/1 and 1/0)
module tb_bin_oct_decoder_strobe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid [2];
    logic [2:0] in_code  [2];
    logic       in_ready [2];
    logic [7:0] dout     [2];
    logic       busy     [2];
    logic       done     [2];

    always #5 clk = ~clk;

    bin_oct_decoder_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CW(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_code(in_code[0]),
        .in_ready(in_ready[0]), .out(dout[0]), .busy(busy[0]), .done(done[0])
    );

    bin_oct_decoder_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CW(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_code(in_code[1]),
        .in_ready(in_ready[1]), .out(dout[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // cyc = index of the interval following the most recent rising edge
    int cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    // expected strobes: {first interval, code}
    int exp_q [2][$];
    int free_int [2];
    bit prev_r = 1'b0;

    task automatic chk(input bit ok, input string name, input int inst, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v0, input bit [2:0] c0, input bit v1, input bit [2:0] c1,
                        output bit a0, output bit a1);
        bit v [2];
        bit [2:0] c [2];
        bit acc [2];
        v[0] = v0; v[1] = v1; c[0] = c0; c[1] = c1;
        if (!prev_r) begin
            exp_q[0].delete();
            exp_q[1].delete();
        end
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            rdy = (cyc >= free_int[i]);
            if (mon_on) chk(in_ready[i] == rdy, "in_ready", i, in_ready[i], rdy);
            in_valid[i] = v[i];
            in_code[i]  = c[i];
            acc[i] = r && v[i] && rdy;
            if (acc[i]) begin
                exp_q[i].push_back(((cyc + 1) << 3) | int'(c[i]));
                free_int[i] = cyc + 1 + hold_of(i) + gap_of(i);
            end
            if (!r) free_int[i] = cyc + 1;
        end
        rst_n = r;
        prev_r = r;
        a0 = acc[0];
        a1 = acc[1];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a0, a1;
        repeat (n) step(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, a0, a1);
    endtask

    // holds in_valid on the selected instances until each has accepted; returns steps taken
    task automatic offer_until(input bit [2:0] code, input bit [1:0] mask, output int steps);
        bit a0, a1;
        bit p0, p1;
        p0 = mask[0];
        p1 = mask[1];
        steps = 0;
        while ((p0 || p1) && steps < 50) begin
            step(1'b1, p0, code, p1, code, a0, a1);
            if (a0) p0 = 1'b0;
            if (a1) p1 = 1'b0;
            steps++;
        end
        chk(!(p0 || p1), "accept_timeout", int'(mask), steps, 50);
    endtask

    bit       active [2] = '{1'b0, 1'b0};
    bit [7:0] cur    [2];
    int       len    [2];

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                if (!rst_q) begin
                    chk(dout[i] == 8'h00, "reset_out", i, dout[i], 0);
                    chk(done[i] == 1'b0, "reset_done", i, done[i], 0);
                    chk(busy[i] == 1'b0, "reset_busy", i, busy[i], 0);
                    active[i] = 1'b0;
                end else begin
                    chk(busy[i] == !in_ready[i], "busy_vs_ready", i, busy[i], !in_ready[i]);
                    chk((dout[i] & (dout[i] - 8'd1)) == 8'h00, "onehot", i, dout[i], 0);
                    if (dout[i] != 8'h00) begin
                        if (!active[i]) begin
                            if (exp_q[i].size() == 0) begin
                                chk(1'b0, "unexpected_strobe", i, dout[i], 0);
                                cur[i] = dout[i];
                            end else begin
                                int e;
                                e = exp_q[i].pop_front();
                                cur[i] = 8'(1 << (e & 7));
                                chk(dout[i] == cur[i], "strobe_value", i, dout[i], cur[i]);
                                chk(cyc == (e >> 3), "strobe_latency", i, cyc, e >> 3);
                            end
                            active[i] = 1'b1;
                            len[i] = 1;
                        end else begin
                            len[i]++;
                            chk(dout[i] == cur[i], "strobe_hold", i, dout[i], cur[i]);
                            chk(len[i] <= hold_of(i), "strobe_too_long", i, len[i], hold_of(i));
                        end
                        chk(done[i] == 1'b0, "done_during_hold", i, done[i], 0);
                    end else if (active[i]) begin
                        chk(len[i] == hold_of(i), "strobe_length", i, len[i], hold_of(i));
                        chk(done[i] == 1'b1, "done_pulse", i, done[i], 1);
                        active[i] = 1'b0;
                    end else begin
                        chk(done[i] == 1'b0, "done_idle", i, done[i], 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a0, a1;
        int n;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        in_code[0] = 3'd0;  in_code[1] = 3'd0;
        free_int[0] = 0;    free_int[1] = 0;
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        repeat (3) step(1'b0, 1'b1, 3'd3, 1'b1, 3'd3, a0, a1);

        step(1'b1, 1'b1, 3'd5, 1'b1, 3'd5, a0, a1);
        chk(a0 && a1, "first_accept", 0, {a0, a1}, 3);
        idle(7);

        for (int c = 0; c < 8; c++) offer_until(3'(c), 2'b11, n);
        idle(6);

        offer_until(3'd1, 2'b11, n);
        idle(1);
        offer_until(3'd6, 2'b01, n);
        chk(n == 5, "stall_wait", 0, n, 5);
        idle(6);

        offer_until(3'd7, 2'b11, n);
        idle(1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, a0, a1);
        idle(1);
        offer_until(3'd2, 2'b11, n);
        chk(n == 1, "accept_after_reset", 0, n, 1);
        idle(6);

        offer_until(3'd2, 2'b10, n);
        offer_until(3'd4, 2'b10, n);
        chk(n == 2, "b2b_rate", 1, n, 2);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            bit r;
            r = ($urandom_range(0, 99) != 0);
            step(r, $urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 9) < 7, 3'($urandom), a0, a1);
        end
        idle(10);

        for (int i = 0; i < 2; i++) begin
            chk(exp_q[i].size() == 0, "queue_drained", i, exp_q[i].size(), 0);
            chk(!active[i], "strobe_closed", i, active[i], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
